csr_arbiter: RTL and testbench
==============================

CSR_ARBITER -- requirements
Module: csr_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0: 0 = round-robin between requesters; 1 = requester 0 always wins.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 rq0_valid / rq1_valid  input  1 each  request from requester 0 (pipeline) / requester 1 (debug).
REQ-005 rq0_ready / rq1_ready  output  1 each  request accepted this cycle.
REQ-006 rqN_op  input  2  requested operation: 00 read, 01 write, 10 set, 11 clear.
REQ-007 rqN_addr  input  12  CSR address.
REQ-008 rqN_wdata  input  32  write data or bit mask.
REQ-009 rspN_valid  output  1  one-cycle response pulse to requester N.
REQ-010 rspN_rdata  output  32  old CSR value; valid while rspN_valid is high.
REQ-011 rspN_err  output  1  write attempted to a read-only CSR; valid while rspN_valid is high.
REQ-012 csr_op  output  2  operation driven to the CSR file: 00 read, 01 write.
REQ-013 csr_addr  output  12  CSR file address.
REQ-014 csr_wdata  output  32  CSR file write data.
REQ-015 csr_rdata  input  32  combinational read data from the CSR file.

Function
REQ-016 The FSM SHALL have four states: IDLE, READ, WRITE, RESP.
REQ-017 In IDLE, if any rqN_valid is high, the block SHALL assert exactly one rqN_ready combinationally.
  - On that handshake it latches op, addr and wdata, records the grantee, and moves to READ.
REQ-018 With FIXED_PRIO=0, when both requesters are valid the grant SHALL go to the requester not granted last.
  - The last-grant pointer resets to 1, so requester 0 wins the first contention.
REQ-019 rqN_ready SHALL be low in every state other than IDLE.
  - Later requests stall; latched request fields are unaffected by input changes.
REQ-020 In READ the block SHALL drive csr_op=00 and csr_addr=latched addr, and capture csr_rdata into an old-value register.
REQ-021 New value: write = wdata; set = old | wdata; clear = old & ~wdata. The computation is 32-bit bitwise with no width change.
REQ-022 A write is needed when op=01, or op is 10/11 with wdata != 0. A read (op=00) never writes.
REQ-023 If a write is needed and addr[11:10]=2'b11 (read-only space), the block SHALL skip WRITE, set the error flag, and go to RESP.
REQ-024 If a write is needed and the address is writable, READ SHALL go to WRITE. Otherwise READ SHALL go to RESP.
REQ-025 In WRITE the block SHALL drive csr_op=01, csr_addr=latched addr and csr_wdata=new value for exactly one cycle, then go to RESP.
REQ-026 In RESP the block SHALL pulse rspN_valid for one cycle, for the grantee only, with rspN_rdata=old value and rspN_err=error flag, then return to IDLE.
REQ-027 Latency from the handshake cycle to rspN_valid: 2 cycles without a write, 3 cycles with a write.
  - Maximum throughput is one request per 3 or 4 cycles, because a handshake is only possible in IDLE.
REQ-028 Outside READ and WRITE: csr_op=00, csr_addr=0, csr_wdata=0.
  - In READ, csr_wdata=0.
  - The CSR file is never written outside WRITE.
REQ-029 Outside RESP, rspN_valid=0, rspN_rdata=0 and rspN_err=0.
REQ-030 The CSR file SHALL see at most one access per cycle, and the two requesters SHALL never be granted in the same cycle.

Reset
REQ-031 While reset_n is low, the block SHALL enter IDLE immediately (asynchronously), independent of clk.
  - All outputs go to 0 and the error flag clears.
  - The last-grant pointer goes to 1.
  - The latched request and old-value registers go to 0.
REQ-032 A transaction interrupted by reset SHALL be dropped: no WRITE and no response after reset deassertion.
  - If reset hits during WRITE, the CSR file sees that single write cycle only.

Verification
REQ-033 Read: rq0 op=00 addr=0x300, csr_rdata=0x1888 -> rsp0_valid 2 cycles after the handshake, rdata=0x1888, err=0, csr_op never 01.
REQ-034 Set: rq1 op=10 addr=0x304 wdata=0x80, old=0x8 -> WRITE cycle with csr_wdata=0x88, then rsp1 rdata=0x8 at cycle 3.
  - Same again with wdata=0 -> no WRITE cycle, response at cycle 2.
REQ-035 Contention: both valid continuously for 4 transactions with FIXED_PRIO=0 -> grants 0,1,0,1; with FIXED_PRIO=1 -> grants 0,0,0,0.
REQ-036 Read-only: rq0 op=01 addr=0xF14 wdata=0x5 -> no csr_op=01 cycle, rsp0_err=1, rdata=current CSR value.
  - Same with op=00 -> err=0.
REQ-037 Clear then reset: rq0 op=11 wdata=0xF, old=0xFF -> csr_wdata=0xF0.
  - Assert reset_n low during READ of a second request -> outputs 0 immediately, no response, next request is serviced normally.

Source files
------------

// File: rtl/csr_arbiter.sv
// rtl/csr_arbiter.sv - two-requester CSR access arbiter with read-modify-write sequencing
module csr_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rq0_valid,
    output logic        rq0_ready,
    input  logic [1:0]  rq0_op,
    input  logic [11:0] rq0_addr,
    input  logic [31:0] rq0_wdata,
    input  logic        rq1_valid,
    output logic        rq1_ready,
    input  logic [1:0]  rq1_op,
    input  logic [11:0] rq1_addr,
    input  logic [31:0] rq1_wdata,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_rdata,
    output logic        rsp0_err,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_rdata,
    output logic        rsp1_err,
    output logic [1:0]  csr_op,
    output logic [11:0] csr_addr,
    output logic [31:0] csr_wdata,
    input  logic [31:0] csr_rdata
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic [1:0]  r_state;
    logic [1:0]  r_op;
    logic [11:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_old;
    logic        r_gnt;
    logic        r_last;
    logic        r_err;

    logic        w_idle;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_need_wr;
    logic        w_ro;
    logic [31:0] w_new;

    // reset_n gates the grant so ready stays low while reset is held
    assign w_idle = (r_state == IDLE) && reset_n;
    assign w_gnt0 = w_idle && rq0_valid && (!rq1_valid || (FIXED_PRIO != 0) || r_last);
    assign w_gnt1 = w_idle && rq1_valid && !w_gnt0;
    assign rq0_ready = w_gnt0;
    assign rq1_ready = w_gnt1;

    assign w_need_wr = (r_op == OP_WRITE) || (r_op[1] && (r_wdata != 32'd0));
    assign w_ro      = (r_addr[11:10] == 2'b11);

    always_comb begin
        w_new = r_old;
        case (r_op)
            OP_WRITE: w_new = r_wdata;
            OP_SET:   w_new = r_old | r_wdata;
            OP_CLEAR: w_new = r_old & ~r_wdata;
            default:  w_new = r_old;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_op    <= 2'b00;
            r_addr  <= 12'd0;
            r_wdata <= 32'd0;
            r_old   <= 32'd0;
            r_gnt   <= 1'b0;
            r_last  <= 1'b1;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_op    <= w_gnt1 ? rq1_op    : rq0_op;
                        r_addr  <= w_gnt1 ? rq1_addr  : rq0_addr;
                        r_wdata <= w_gnt1 ? rq1_wdata : rq0_wdata;
                        r_gnt   <= w_gnt1;
                        r_last  <= w_gnt1;
                        r_err   <= 1'b0;
                        r_state <= READ;
                    end
                end
                READ: begin
                    r_old <= csr_rdata;
                    if (w_need_wr && w_ro) begin
                        r_err   <= 1'b1;
                        r_state <= RESP;
                    end else if (w_need_wr) begin
                        r_state <= WRITE;
                    end else begin
                        r_state <= RESP;
                    end
                end
                WRITE:   r_state <= RESP;
                RESP: begin
                    r_err   <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign csr_op    = (r_state == WRITE) ? 2'b01 : 2'b00;
    assign csr_addr  = ((r_state == READ) || (r_state == WRITE)) ? r_addr : 12'd0;
    assign csr_wdata = (r_state == WRITE) ? w_new : 32'd0;

    assign rsp0_valid = (r_state == RESP) && !r_gnt;
    assign rsp1_valid = (r_state == RESP) && r_gnt;
    assign rsp0_rdata = rsp0_valid ? r_old : 32'd0;
    assign rsp1_rdata = rsp1_valid ? r_old : 32'd0;
    assign rsp0_err   = rsp0_valid && r_err;
    assign rsp1_err   = rsp1_valid && r_err;
endmodule

// File: tb/tb_csr_arbiter.sv
// tb/tb_csr_arbiter.sv - directed vector bench for csr_arbiter
module tb_csr_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        rq0_valid, rq1_valid;
    logic [1:0]  rq0_op, rq1_op;
    logic [11:0] rq0_addr, rq1_addr;
    logic [31:0] rq0_wdata, rq1_wdata;

    logic        rq0_ready, rq1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic [31:0] rsp0_rdata, rsp1_rdata, csr_wdata, csr_rdata;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;

    logic        f_rq0_ready, f_rq1_ready, f_rsp0_valid, f_rsp1_valid, f_rsp0_err, f_rsp1_err;
    logic [31:0] f_rsp0_rdata, f_rsp1_rdata, f_csr_wdata, f_csr_rdata;
    logic [1:0]  f_csr_op;
    logic [11:0] f_csr_addr;

    logic [31:0] mem  [0:4095];
    logic [31:0] fmem [0:4095];
    assign csr_rdata   = mem[csr_addr];
    assign f_csr_rdata = fmem[f_csr_addr];
    always @(posedge clk) begin
        if (csr_op == 2'b01)   mem[csr_addr] = csr_wdata;
        if (f_csr_op == 2'b01) fmem[f_csr_addr] = f_csr_wdata;
    end

    csr_arbiter #(.FIXED_PRIO(0)) dut (
        .clk(clk), .reset_n(reset_n),
        .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_op(rq0_op), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
        .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_op(rq1_op), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata)
    );

    csr_arbiter #(.FIXED_PRIO(1)) dut_fp (
        .clk(clk), .reset_n(reset_n),
        .rq0_valid(rq0_valid), .rq0_ready(f_rq0_ready), .rq0_op(rq0_op), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
        .rq1_valid(rq1_valid), .rq1_ready(f_rq1_ready), .rq1_op(rq1_op), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
        .rsp0_valid(f_rsp0_valid), .rsp0_rdata(f_rsp0_rdata), .rsp0_err(f_rsp0_err),
        .rsp1_valid(f_rsp1_valid), .rsp1_rdata(f_rsp1_rdata), .rsp1_err(f_rsp1_err),
        .csr_op(f_csr_op), .csr_addr(f_csr_addr), .csr_wdata(f_csr_wdata), .csr_rdata(f_csr_rdata)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rq;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] old;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_nw;
        int          exp_lat;
        logic [31:0] exp_wdata;
        logic [31:0] exp_mem;
    } vec_t;

    vec_t vecs [10];

    // Issues one request and watches the following cycles for the response and CSR writes.
    task automatic run_req(input logic rq, input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                           output int lat, output logic [31:0] rd, output logic er, output int nw,
                           output logic [31:0] lw, output int nresp, output int wrong);
        bit hs;
        lat = -1; rd = 32'd0; er = 1'b0; nw = 0; lw = 32'd0; nresp = 0; wrong = 0; hs = 1'b0;
        @(negedge clk);
        rq0_valid = !rq; rq1_valid = rq;
        if (rq) begin rq1_op = op; rq1_addr = addr; rq1_wdata = wd; end
        else    begin rq0_op = op; rq0_addr = addr; rq0_wdata = wd; end
        for (int k = 0; k < 5 && !hs; k++) begin
            #1;
            if (rq ? rq1_ready : rq0_ready) hs = 1'b1;
            else @(negedge clk);
        end
        check("handshake", {31'd0, hs}, 32'd1);
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            rq0_valid = 1'b0; rq1_valid = 1'b0;
            #1;
            if (csr_op == 2'b01) begin nw++; lw = csr_wdata; end
            if (rq ? rsp1_valid : rsp0_valid) begin
                nresp++;
                if (lat < 0) begin
                    lat = c;
                    rd  = rq ? rsp1_rdata : rsp0_rdata;
                    er  = rq ? rsp1_err : rsp0_err;
                end
            end
            if (rq ? rsp0_valid : rsp1_valid) wrong++;
        end
    endtask

    int          lat, nw, nresp, wrong, seen, g0, g1;
    logic [31:0] rd, lw;
    logic        er;
    logic [3:0]  gr, fgr;

    initial begin
        vecs[0] = '{1'b0, 2'b00, 12'h300, 32'h0,        32'h1888, 32'h1888, 1'b0, 0, 2, 32'h0,        32'h1888};
        vecs[1] = '{1'b1, 2'b10, 12'h304, 32'h80,       32'h8,    32'h8,    1'b0, 1, 3, 32'h88,       32'h88};
        vecs[2] = '{1'b1, 2'b10, 12'h304, 32'h0,        32'h8,    32'h8,    1'b0, 0, 2, 32'h0,        32'h8};
        vecs[3] = '{1'b0, 2'b01, 12'hF14, 32'h5,        32'h1234, 32'h1234, 1'b1, 0, 2, 32'h0,        32'h1234};
        vecs[4] = '{1'b0, 2'b00, 12'hF14, 32'h5,        32'h1234, 32'h1234, 1'b0, 0, 2, 32'h0,        32'h1234};
        vecs[5] = '{1'b0, 2'b11, 12'h308, 32'hF,        32'hFF,   32'hFF,   1'b0, 1, 3, 32'hF0,       32'hF0};
        vecs[6] = '{1'b1, 2'b01, 12'h010, 32'hDEADBEEF, 32'h11,   32'h11,   1'b0, 1, 3, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[7] = '{1'b0, 2'b11, 12'hC00, 32'h0,        32'h77,   32'h77,   1'b0, 0, 2, 32'h0,        32'h77};
        vecs[8] = '{1'b1, 2'b10, 12'hFFF, 32'h1,        32'hA0,   32'hA0,   1'b1, 0, 2, 32'h0,        32'hA0};
        vecs[9] = '{1'b0, 2'b01, 12'hBFF, 32'h0,        32'h3C,   32'h3C,   1'b0, 1, 3, 32'h0,        32'h0};

        reset_n = 1'b0;
        rq0_valid = 1'b1; rq1_valid = 1'b1;
        rq0_op = 2'b00; rq1_op = 2'b00; rq0_addr = 12'h0; rq1_addr = 12'h0;
        rq0_wdata = 32'h0; rq1_wdata = 32'h0;
        #12;
        check("rst_rq0_ready", {31'd0, rq0_ready}, 32'd0);
        check("rst_rq1_ready", {31'd0, rq1_ready}, 32'd0);
        check("rst_csr_op", {30'd0, csr_op}, 32'd0);
        check("rst_csr_addr", {20'd0, csr_addr}, 32'd0);
        check("rst_rsp_valid", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
        @(negedge clk);
        rq0_valid = 1'b0; rq1_valid = 1'b0;
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            mem[vecs[i].addr] = vecs[i].old;
            fmem[vecs[i].addr] = vecs[i].old;
            run_req(vecs[i].rq, vecs[i].op, vecs[i].addr, vecs[i].wdata, lat, rd, er, nw, lw, nresp, wrong);
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
            check($sformatf("v%0d_nwrites", i), nw, vecs[i].exp_nw);
            if (vecs[i].exp_nw > 0) check($sformatf("v%0d_csr_wdata", i), lw, vecs[i].exp_wdata);
            check($sformatf("v%0d_nresp", i), nresp, 1);
            check($sformatf("v%0d_wrong_rsp", i), wrong, 0);
            check($sformatf("v%0d_mem", i), mem[vecs[i].addr], vecs[i].exp_mem);
        end

        // Reset asserted while the second request sits in READ.
        @(negedge clk);
        mem[12'h30C] = 32'h55;
        rq0_valid = 1'b1; rq0_op = 2'b01; rq0_addr = 12'h30C; rq0_wdata = 32'hAA;
        #1;
        check("rst_seq_ready", {31'd0, rq0_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        rq0_valid = 1'b0;
        #1;
        check("rst_seq_read_addr", {20'd0, csr_addr}, 32'h30C);
        reset_n = 1'b0;
        #1;
        check("rst_seq_csr_addr", {20'd0, csr_addr}, 32'd0);
        check("rst_seq_csr_op", {30'd0, csr_op}, 32'd0);
        check("rst_seq_rsp", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (csr_op == 2'b01 || rsp0_valid || rsp1_valid) seen++;
        end
        check("rst_seq_dropped", seen, 0);
        check("rst_seq_mem", mem[12'h30C], 32'h55);
        run_req(1'b0, 2'b00, 12'h30C, 32'h0, lat, rd, er, nw, lw, nresp, wrong);
        check("post_rst_latency", lat, 2);
        check("post_rst_rdata", rd, 32'h55);

        // Contention: both requesters held valid for four grants from a fresh reset.
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        rq0_op = 2'b00; rq0_addr = 12'h300; rq0_wdata = 32'h0;
        rq1_op = 2'b00; rq1_addr = 12'h304; rq1_wdata = 32'h0;
        rq0_valid = 1'b1; rq1_valid = 1'b1;
        g0 = 0; g1 = 0; gr = 4'h0; fgr = 4'h0; seen = 0;
        for (int c = 0; c < 40 && (g0 < 4 || g1 < 4); c++) begin
            #1;
            if ((rq0_ready && rq1_ready) || (f_rq0_ready && f_rq1_ready)) seen++;
            if ((rq0_ready || rq1_ready) && g0 < 4) begin gr[g0] = rq1_ready; g0++; end
            if ((f_rq0_ready || f_rq1_ready) && g1 < 4) begin fgr[g1] = f_rq1_ready; g1++; end
            @(negedge clk);
        end
        rq0_valid = 1'b0; rq1_valid = 1'b0;
        check("cont_rr_count", g0, 4);
        check("cont_fp_count", g1, 4);
        check("cont_double_grant", seen, 0);
        check("cont_rr_grants", {28'd0, gr}, 32'b1010);
        check("cont_fp_grants", {28'd0, fgr}, 32'b0000);
        repeat (6) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
